// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: ALU op codes, FSM states and sizes.
package div_unit_pkg;
  localparam int XLEN       = 64;
  localparam int DIV_W_ITER = 32;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    DIV     = 5'd16,
    DIVU    = 5'd17,
    REM     = 5'd18,
    REMU    = 5'd19,
    DIVW    = 5'd20,
    DIVUW   = 5'd21,
    REMW    = 5'd22,
    REMUW   = 5'd23
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} div_state_t;
endpackage

// File: rtl/div_unit_prep.sv
// Operand conditioning for the divider: W extension, sign split, absolute values, special cases.
module div_prep
  import div_unit_pkg::*;
(
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_ext_a,
  output logic [XLEN-1:0] o_abs_a,
  output logic [XLEN-1:0] o_abs_b,
  output logic            o_sign_q,
  output logic            o_sign_r,
  output logic            o_is_w,
  output logic            o_rem_sel,
  output logic            o_is_div,
  output logic            o_div_zero,
  output logic            o_ovf
);
  logic            w_signed;
  logic [XLEN-1:0] w_ext_b;
  logic            w_sa, w_sb;

  always_comb begin
    w_signed  = 1'b0;
    o_is_w    = 1'b0;
    o_rem_sel = 1'b0;
    o_is_div  = 1'b1;
    case (i_op)
      DIV:     w_signed = 1'b1;
      DIVU:    ;
      REM:     begin w_signed = 1'b1; o_rem_sel = 1'b1; end
      REMU:    o_rem_sel = 1'b1;
      DIVW:    begin w_signed = 1'b1; o_is_w = 1'b1; end
      DIVUW:   o_is_w = 1'b1;
      REMW:    begin w_signed = 1'b1; o_is_w = 1'b1; o_rem_sel = 1'b1; end
      REMUW:   begin o_is_w = 1'b1; o_rem_sel = 1'b1; end
      default: o_is_div = 1'b0;
    endcase

    if (o_is_w) begin
      o_ext_a = {{(XLEN-DIV_W_ITER){w_signed & i_a[DIV_W_ITER-1]}}, i_a[DIV_W_ITER-1:0]};
      w_ext_b = {{(XLEN-DIV_W_ITER){w_signed & i_b[DIV_W_ITER-1]}}, i_b[DIV_W_ITER-1:0]};
    end else begin
      o_ext_a = i_a;
      w_ext_b = i_b;
    end

    w_sa     = w_signed & o_ext_a[XLEN-1];
    w_sb     = w_signed & w_ext_b[XLEN-1];
    o_abs_a  = w_sa ? -o_ext_a : o_ext_a;
    o_abs_b  = w_sb ? -w_ext_b : w_ext_b;
    o_sign_q = w_sa ^ w_sb;
    o_sign_r = w_sa;

    o_div_zero = o_is_div && (w_ext_b == '0);
    // Operands are already extended, so the W most-negative value is its 64-bit sign extension.
    o_ovf = o_is_div && w_signed && (w_ext_b == '1) &&
            (o_ext_a == (o_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  end
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle, valid/ready result port.
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  div_state_t      r_state;
  logic [4:0]      r_op;
  logic [XLEN-1:0] r_a, r_b, r_rem, r_dvd, r_dvs, r_result;
  logic [6:0]      r_cnt;
  logic            r_sign_q, r_sign_r, r_is_w, r_rem_sel, r_is_div, r_out_valid;

  logic [XLEN-1:0] w_ext_a, w_abs_a, w_abs_b;
  logic            w_sign_q, w_sign_r, w_is_w, w_rem_sel, w_is_div, w_div_zero, w_ovf;
  logic [XLEN:0]   w_trial, w_diff;
  logic            w_sub_ok;
  logic [XLEN-1:0] w_q, w_r, w_sel, w_final;

  div_prep u_prep (
    .i_op(r_op), .i_a(r_a), .i_b(r_b),
    .o_ext_a(w_ext_a), .o_abs_a(w_abs_a), .o_abs_b(w_abs_b),
    .o_sign_q(w_sign_q), .o_sign_r(w_sign_r), .o_is_w(w_is_w), .o_rem_sel(w_rem_sel),
    .o_is_div(w_is_div), .o_div_zero(w_div_zero), .o_ovf(w_ovf)
  );

  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = r_out_valid;
  assign result    = r_result;

  always_comb begin
    w_trial  = {r_rem, r_dvd[XLEN-1]};
    w_diff   = w_trial - {1'b0, r_dvs};
    w_sub_ok = !w_diff[XLEN];
    w_q      = r_sign_q ? -r_dvd : r_dvd;
    w_r      = r_sign_r ? -r_rem : r_rem;
    w_sel    = r_rem_sel ? w_r : w_q;
    if (!r_is_div)   w_final = '0;
    else if (r_is_w) w_final = {{(XLEN-DIV_W_ITER){w_sel[DIV_W_ITER-1]}}, w_sel[DIV_W_ITER-1:0]};
    else             w_final = w_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cnt       <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_op    <= op;
          r_a     <= a;
          r_b     <= b;
          r_state <= PREP;
        end
        PREP: begin
          r_sign_q  <= w_sign_q;
          r_sign_r  <= w_sign_r;
          r_is_w    <= w_is_w;
          r_rem_sel <= w_rem_sel;
          r_is_div  <= w_is_div;
          r_dvs     <= w_abs_b;
          r_rem     <= '0;
          r_cnt     <= w_is_w ? 7'(DIV_W_ITER) : 7'(XLEN);
          if (!w_is_div) begin
            r_state <= DONE;
          end else if (w_div_zero) begin
            // Special results are staged unsigned so DONE passes them through untouched.
            r_dvd    <= '1;
            r_rem    <= w_ext_a;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_state  <= DONE;
          end else if (w_ovf) begin
            r_dvd    <= w_ext_a;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_state  <= DONE;
          end else begin
            // W dividends sit in the top half so 32 shifts bring every bit through.
            r_dvd   <= w_is_w ? {w_abs_a[DIV_W_ITER-1:0], {DIV_W_ITER{1'b0}}} : w_abs_a;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_sub_ok ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
          r_dvd <= {r_dvd[XLEN-2:0], w_sub_ok};
          r_cnt <= r_cnt - 7'd1;
          if (r_cnt == 7'd1) r_state <= DONE;
        end
        DONE: begin
          if (!r_out_valid) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: values, latency, handshake, flush and reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = 5'd0;
  logic [63:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  // Issue one request, wait (bounded) for out_valid, then take the result.
  task automatic do_op(input logic [4:0] o, input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] res, output int lat, output bit busy_ok);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    busy_ok = !in_ready;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (in_ready) busy_ok = 1'b0;
      if (out_valid) begin lat = k; break; end
    end
    res = result;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_hi got %b exp 0", in_ready); end
    @(negedge clk); reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_lo got %b exp 1", in_ready); end
  endtask

  task automatic test_unsigned;
    logic [63:0] r; int lat; bit bz;
    do_op(DIVU, 64'd100, 64'd7, r, lat, bz);
    checks++; if (r !== 64'd14) begin errors++; $display("FAIL divu_val got %h exp %h", r, 64'd14); end
    checks++; if (lat !== 66) begin errors++; $display("FAIL divu_lat got %0d exp 66", lat); end
    checks++; if (bz !== 1'b1) begin errors++; $display("FAIL divu_busy got %b exp 1", bz); end
    do_op(REMU, 64'd100, 64'd7, r, lat, bz);
    checks++; if (r !== 64'd2) begin errors++; $display("FAIL remu_val got %h exp %h", r, 64'd2); end
  endtask

  task automatic test_signed;
    logic [63:0] r; int lat; bit bz;
    do_op(DIV, -64'sd20, 64'd3, r, lat, bz);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL div_neg_a got %h exp fffffffffffffffa", r); end
    do_op(REM, -64'sd20, 64'd3, r, lat, bz);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL rem_neg_a got %h exp fffffffffffffffe", r); end
    do_op(DIV, 64'd20, -64'sd3, r, lat, bz);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL div_neg_b got %h exp fffffffffffffffa", r); end
    checks++; if (lat !== 66) begin errors++; $display("FAIL div_neg_b_lat got %0d exp 66", lat); end
    do_op(REM, 64'd20, -64'sd3, r, lat, bz);
    checks++; if (r !== 64'd2) begin errors++; $display("FAIL rem_neg_b got %h exp 2", r); end
  endtask

  task automatic test_div_zero;
    logic [63:0] r; int lat; bit bz;
    do_op(DIV, 64'd5, 64'd0, r, lat, bz);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dz_div got %h exp ffffffffffffffff", r); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL dz_lat got %0d exp 2", lat); end
    do_op(REMU, 64'd5, 64'd0, r, lat, bz);
    checks++; if (r !== 64'd5) begin errors++; $display("FAIL dz_remu got %h exp 5", r); end
    do_op(REMW, 64'h1_8000_0000, 64'd0, r, lat, bz);
    checks++; if (r !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL dz_remw got %h exp ffffffff80000000", r); end
  endtask

  task automatic test_overflow;
    logic [63:0] r; int lat; bit bz;
    do_op(DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bz);
    checks++; if (r !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_div got %h exp 8000000000000000", r); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL ovf_lat got %0d exp 2", lat); end
    do_op(REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bz);
    checks++; if (r !== 64'd0) begin errors++; $display("FAIL ovf_rem got %h exp 0", r); end
    do_op(DIVW, 64'h8000_0000, 64'hFFFF_FFFF, r, lat, bz);
    checks++; if (r !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL ovf_divw got %h exp ffffffff80000000", r); end
  endtask

  task automatic test_word;
    logic [63:0] r; int lat; bit bz;
    do_op(DIVW, 64'h0000_0001_FFFF_FFF8, 64'd2, r, lat, bz);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL divw_val got %h exp fffffffffffffffc", r); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL divw_lat got %0d exp 34", lat); end
    do_op(DIVUW, 64'hFFFF_FFFF, 64'd2, r, lat, bz);
    checks++; if (r !== 64'h7FFF_FFFF) begin errors++; $display("FAIL divuw_val got %h exp 7fffffff", r); end
    do_op(REMUW, 64'hFFFF_FFFF, 64'd2, r, lat, bz);
    checks++; if (r !== 64'd1) begin errors++; $display("FAIL remuw_val got %h exp 1", r); end
  endtask

  task automatic test_nondiv;
    logic [63:0] r; int lat; bit bz;
    do_op(ALU_ADD, 64'd9, 64'd4, r, lat, bz);
    checks++; if (r !== 64'd0) begin errors++; $display("FAIL nondiv_val got %h exp 0", r); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL nondiv_lat got %0d exp 2", lat); end
  endtask

  task automatic test_hold;
    bit seen = 1'b0;
    @(negedge clk);
    op = DIVU; a = 64'd1000; b = 64'd10; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hold_timeout got %b exp 1", seen); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (result !== 64'd100) begin errors++; $display("FAIL hold_result got %h exp %h", result, 64'd100); end
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_flags got ov=%b ir=%b exp ov=1 ir=0", out_valid, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_flush_calc;
    bit rose = 1'b0;
    @(negedge clk);
    op = DIV; a = 64'd100; b = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_calc_ready got %b exp 1", in_ready); end
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1'b1;
    end
    checks++; if (rose !== 1'b0) begin errors++; $display("FAIL flush_calc_valid got %b exp 0", rose); end
  endtask

  task automatic test_flush_accept;
    bit rose = 1'b0;
    @(negedge clk);
    op = DIVU; a = 64'd50; b = 64'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; flush = 1'b0; end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_acc_ready got %b exp 1", in_ready); end
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1'b1;
    end
    checks++; if (rose !== 1'b0) begin errors++; $display("FAIL flush_acc_valid got %b exp 0", rose); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] r; int lat; bit bz;
    @(negedge clk);
    op = DIVU; a = 64'd77; b = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (result !== 64'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid got res=%h ov=%b exp res=0 ov=0", result, out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready got %b exp 0", in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_idle got %b exp 1", in_ready); end
    do_op(DIVU, 64'd77, 64'd7, r, lat, bz);
    checks++; if (r !== 64'd11) begin errors++; $display("FAIL reset_mid_after got %h exp %h", r, 64'd11); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_word();
    test_nondiv();
    test_hold();
    test_flush_calc();
    test_flush_accept();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
